// File: rtl/uart_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_mmio : memory-mapped 8N1 UART with 4-deep TX/RX FIFOs and level IRQ  |
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+

module uart_fifo4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic [2:0] count
);
  logic [3:0][7:0] mem_q, mem_d;
  logic [1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            do_push, do_pop;

  // A push into a full FIFO only lands when the head leaves on the same edge.
  always_comb begin
    do_pop  = pop && (cnt_q != 3'd0);
    do_push = push && ((cnt_q != 3'd4) || do_pop);
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wp_q] = din;
      wp_d        = wp_q + 2'd1;
    end
    if (do_pop) rp_d = rp_q + 2'd1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rp_q];
  assign count = cnt_q;
endmodule

module uart_mmio #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic        reset,
  input  logic        clk,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        IRQ
);
  localparam int              DIV       = CLK_FREQ / BAUD;
  localparam int              CW        = $clog2(DIV);
  localparam logic [CW-1:0]   DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [31:0]     ADDR_TXD  = 32'h4000_0018;
  localparam logic [31:0]     ADDR_RXD  = 32'h4000_001C;
  localparam logic [31:0]     ADDR_CON  = 32'h4000_0020;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic       sel_txd, sel_rxd, sel_con, con_wr;
  logic       tx_push, tx_pop, tx_full, tx_done;
  logic       rx_push, rx_pop, rx_valid, ovr_set, fe_set;
  logic [7:0] tx_head, rx_head;
  logic [2:0] tx_count, rx_count;
  logic       unused_wdata;

  assign sel_txd      = (Address == ADDR_TXD);
  assign sel_rxd      = (Address == ADDR_RXD);
  assign sel_con      = (Address == ADDR_CON);
  assign con_wr       = MemWrite && sel_con;
  assign tx_full      = (tx_count == 3'd4);
  assign tx_push      = MemWrite && sel_txd && !tx_full;
  assign rx_pop       = MemRead && sel_rxd;
  assign rx_valid     = (rx_count != 3'd0);
  assign ovr_set      = rx_push && (rx_count == 3'd4) && !rx_pop;
  assign unused_wdata = ^Write_data[31:8];

  // ---------------- transmit path ----------------
  state_t        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d, tx_tick;

  uart_fifo4 u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop),
    .din(Write_data[7:0]), .head(tx_head), .count(tx_count)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    tx_tick    = (tx_cnt_q == DIV_LAST);
    if (tx_state_q != S_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
    case (tx_state_q)
      S_IDLE: if (tx_count != 3'd0) begin
        tx_pop     = 1'b1;
        tx_shift_d = tx_head;
        tx_cnt_d   = '0;
        tx_state_d = S_START;
      end
      S_START: if (tx_tick) begin
        tx_bit_d   = '0;
        tx_state_d = S_DATA;
      end
      S_DATA: if (tx_tick) begin
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_bit_d   = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
      end
      S_STOP: if (tx_tick) begin
        // Chain straight into the next frame so queued bytes go out gap-free.
        if (tx_count != 3'd0) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_state_d = S_START;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    case (tx_state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_done = (tx_count == 3'd0) && (tx_state_q == S_IDLE);

  // ---------------- receive path ----------------
  state_t        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;

  uart_fifo4 u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop),
    .din(rx_shift_q), .head(rx_head), .count(rx_count)
  );

  always_comb begin
    rx_s1_d    = uart_rx;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    fe_set     = 1'b0;
    if (rx_state_q != S_IDLE) rx_cnt_d = rx_cnt_q + CW'(1);
    case (rx_state_q)
      S_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_cnt_d   = '0;
        rx_state_d = S_START;
      end
      S_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == DIV_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
      end
      S_STOP: if (rx_cnt_q == DIV_LAST) begin
        rx_cnt_d   = '0;
        rx_state_d = S_IDLE;
        rx_push    = rx_s2_q;
        fe_set     = !rx_s2_q;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // ---------------- control / status ----------------
  logic rxie_q, rxie_d, txie_q, txie_d, ovr_q, ovr_d, fe_q, fe_d, irq_q, irq_d;

  always_comb begin
    rxie_d = con_wr ? Write_data[5] : rxie_q;
    txie_d = con_wr ? Write_data[6] : txie_q;
    ovr_d  = (ovr_q && !(con_wr && Write_data[3])) || ovr_set;
    fe_d   = (fe_q  && !(con_wr && Write_data[4])) || fe_set;
    irq_d  = (rxie_q && rx_valid) || (txie_q && tx_done);
  end

  always_comb begin
    Read_data = '0;
    if (sel_rxd)
      Read_data = {24'b0, rx_valid ? rx_head : 8'h00};
    else if (sel_con)
      Read_data = {25'b0, txie_q, rxie_q, fe_q, ovr_q, rx_valid, tx_done, tx_full};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rxie_q     <= 1'b0;
      txie_q     <= 1'b0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rxie_q     <= rxie_d;
      txie_q     <= txie_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      irq_q      <= irq_d;
    end
  end

  assign uart_tx = tx_q;
  assign IRQ     = irq_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_mmio : directed self-checking bench for uart_mmio (DIV = 16)      |
// | Revision     : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_uart_mmio;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        IRQ;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] rd;
  logic [9:0]  frame;
  logic [7:0]  cap_b;
  logic        cap_ok;
  int          lows;
  logic [7:0]  tx_bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  uart_mmio #(.CLK_FREQ(16), .BAUD(1)) dut (
    .reset(reset), .clk(clk), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic peek(input logic [31:0] addr, output logic [31:0] data);
    Address = addr;
    #1 data = Read_data;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    Address = addr; Write_data = data; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    Address = addr; MemRead = 1'b1;
    #1 data = Read_data;
    @(negedge clk);
    MemRead = 1'b0;
  endtask

  // mode 1 checks the RX-valid rise at the stop sample; mode 2 adds the IRQ rise.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int mode);
    logic [9:0]  f;
    logic [31:0] con;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      if (mode != 0 && (k == 154 || k == 155)) begin
        peek(A_CON, con);
        check($sformatf("rx_valid_k%0d", k), {31'b0, con[2]}, (k == 155) ? 32'd1 : 32'd0);
      end
      if (mode == 2 && (k == 155 || k == 156))
        check($sformatf("irq_k%0d", k), {31'b0, IRQ}, (k == 156) ? 32'd1 : 32'd0);
      uart_rx = f[k/16];
    end
    @(negedge clk);
    uart_rx = 1'b1;
    @(negedge clk);
  endtask

  task automatic capture_tx(output logic [7:0] b, output logic ok);
    int w;
    w = 0; ok = 1'b0; b = '0;
    while (uart_tx !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (uart_tx === 1'b0) begin
      ok = 1'b1;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (16) @(negedge clk);
      if (uart_tx !== 1'b1) ok = 1'b0;
    end
  endtask

  initial begin
    // Reset state, both during and after reset
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_irq", {31'b0, IRQ}, 32'd0);
    peek(A_CON, rd); check("rst_con", rd, 32'h02);
    peek(A_RXD, rd); check("rst_rxd", rd, 32'h00);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    peek(A_CON, rd); check("post_rst_con", rd, 32'h02);

    // TXIE with TX done: IRQ registered one cycle after the CON write
    bus_write(A_CON, 32'h40);
    check("txie_irq_same", {31'b0, IRQ}, 32'd0);
    @(negedge clk);
    check("txie_irq_next", {31'b0, IRQ}, 32'd1);
    bus_write(A_CON, 32'h00);
    @(negedge clk);
    check("txie_irq_clear", {31'b0, IRQ}, 32'd0);

    // Single TX byte 0xA5
    bus_write(A_TXD, 32'hA5);
    check("tx_idle_at_store", {31'b0, uart_tx}, 32'd1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      if (k % 16 == 0 || k % 16 == 15)
        check($sformatf("tx_a5_bit%0d_c%0d", k / 16, k % 16), {31'b0, uart_tx}, {31'b0, frame[k/16]});
      if (k == 80 || k == 159) begin
        peek(A_CON, rd);
        check($sformatf("tx_done_busy_k%0d", k), {31'b0, rd[1]}, 32'd0);
      end
    end
    @(negedge clk);
    peek(A_CON, rd); check("tx_done_after", rd, 32'h02);

    // TX FIFO full: six consecutive stores, five frames expected
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          MemWrite = 1'b0;
          if (i == 5) begin
            peek(A_CON, rd);
            check("tx_full_after5", rd, 32'h01);
          end
          Address = A_TXD; Write_data = {24'b0, tx_bytes[i]}; MemWrite = 1'b1;
        end
        @(negedge clk);
        MemWrite = 1'b0;
        peek(A_CON, rd); check("tx_full_after6", rd, 32'h01);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          capture_tx(cap_b, cap_ok);
          check($sformatf("tx_frame%0d_ok", i), {31'b0, cap_ok}, 32'd1);
          check($sformatf("tx_frame%0d_data", i), {24'b0, cap_b}, {24'b0, tx_bytes[i]});
        end
      end
    join
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("tx_no_6th_frame", lows, 0);
    peek(A_CON, rd); check("tx_full_done", rd, 32'h02);

    // RX loopback of 0x3C
    send_frame(8'h3C, 1'b1, 1);
    bus_read(A_RXD, rd); check("rx_data_3c", rd, 32'h3C);
    peek(A_CON, rd); check("rx_con_after_pop", rd, 32'h02);

    // Overrun: five frames, FIFO keeps the first four
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
    peek(A_CON, rd); check("rx_overrun_con", rd, 32'h0E);
    for (int i = 1; i <= 4; i++) begin
      bus_read(A_RXD, rd);
      check($sformatf("rx_ovr_data%0d", i), rd, i);
    end
    bus_read(A_RXD, rd); check("rx_empty_read", rd, 32'h00);
    peek(A_CON, rd); check("rx_ovr_sticky", rd, 32'h0A);

    // Framing error, then write-1-to-clear
    send_frame(8'h77, 1'b0, 0);
    peek(A_CON, rd); check("rx_framing_con", rd, 32'h1A);
    bus_write(A_CON, 32'h18);
    peek(A_CON, rd); check("con_w1c", rd, 32'h02);

    // RX interrupt
    bus_write(A_CON, 32'h20);
    peek(A_CON, rd); check("rxie_set", rd, 32'h22);
    check("rxie_irq_idle", {31'b0, IRQ}, 32'd0);
    send_frame(8'h5A, 1'b1, 2);
    bus_read(A_RXD, rd); check("rx_data_5a", rd, 32'h5A);
    check("irq_hold_at_pop", {31'b0, IRQ}, 32'd1);
    @(negedge clk);
    check("irq_drop_after_pop", {31'b0, IRQ}, 32'd0);

    // Mid-frame asynchronous reset with an RX byte pending
    send_frame(8'h99, 1'b1, 0);
    check("irq_pending", {31'b0, IRQ}, 32'd1);
    bus_write(A_TXD, 32'h00);
    repeat (40) @(negedge clk);
    check("tx_midframe_low", {31'b0, uart_tx}, 32'd0);
    #1 reset = 1'b1;
    #1 check("tx_async_reset", {31'b0, uart_tx}, 32'd1);
    check("irq_async_reset", {31'b0, IRQ}, 32'd0);
    peek(A_CON, rd); check("con_async_reset", rd, 32'h02);
    peek(A_RXD, rd); check("rxd_async_reset", rd, 32'h00);
    @(negedge clk); reset = 1'b0;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("tx_quiet_after_reset", lows, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
